// File: rtl/stack_cpu_pkg.sv
// Shared types for the 8-bit stack machine: field widths, opcode and controller state encodings.
package stack_cpu_pkg;

  localparam int OPC_W  = 3;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 8;

  typedef enum logic [OPC_W-1:0] {
    OP_ADD   = 3'd0,
    OP_SUB   = 3'd1,
    OP_AND   = 3'd2,
    OP_NOT   = 3'd3,
    OP_PUSH  = 3'd4,
    OP_POP   = 3'd5,
    OP_JUMP  = 3'd6,
    OP_JUMPZ = 3'd7
  } opcode_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  function automatic logic is_binop(opcode_t op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND);
  endfunction

endpackage

// File: rtl/stack_core_ctrl_stack_file.sv
// Operand stack register file: single-cycle push/pop/top-or-NOS rewrite, no internal backpressure.
// Callers guarantee push only when not full and pop/rewrite only with enough entries.
module stack_file
  import stack_cpu_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int IW = $clog2(DEPTH),
  localparam int CW = IW + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear_i,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_dat_i,
  input  logic              pop_i,
  input  logic              wr_top_i,
  input  logic              wr_nos_i,
  input  logic [DATA_W-1:0] wr_dat_i,
  output logic [DATA_W-1:0] tos_o,
  output logic [DATA_W-1:0] nos_o,
  output logic [CW-1:0]     depth_o,
  output logic              full_o,
  output logic              empty_o
);

  logic [DATA_W-1:0] stk_q [DEPTH];
  logic [CW-1:0]     depth_q;
  logic [IW-1:0]     top_idx, nos_idx, push_idx;

  assign top_idx  = IW'(depth_q - CW'(1));
  assign nos_idx  = IW'(depth_q - CW'(2));
  assign push_idx = depth_q[IW-1:0];

  assign empty_o = (depth_q == '0);
  assign full_o  = (depth_q == CW'(DEPTH));
  assign depth_o = depth_q;
  assign tos_o   = empty_o ? '0 : stk_q[top_idx];
  assign nos_o   = (depth_q >= CW'(2)) ? stk_q[nos_idx] : '0;

  // A binary op rewrites NOS and pops in the same cycle, leaving the result on top.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      depth_q <= '0;
      for (int i = 0; i < DEPTH; i++) stk_q[i] <= '0;
    end else if (clear_i) begin
      depth_q <= '0;
    end else begin
      if (push_i)   stk_q[push_idx] <= push_dat_i;
      if (wr_top_i) stk_q[top_idx]  <= wr_dat_i;
      if (wr_nos_i) stk_q[nos_idx]  <= wr_dat_i;
      if (push_i)     depth_q <= depth_q + CW'(1);
      else if (pop_i) depth_q <= depth_q - CW'(1);
    end
  end

endmodule

// File: rtl/stack_core_ctrl.sv
// Two-cycle FETCH/EXEC controller for the stack machine; sole master of the unified 32x8 memory.
// No backpressure: start is honoured only from IDLE/HALT, memory read data is used combinationally.
module stack_core_ctrl
  import stack_cpu_pkg::*;
#(
  parameter int               STACK_DEPTH = 8,
  parameter logic [ADDR_W-1:0] RESET_PC   = 5'd0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  output logic [ADDR_W-1:0]              mem_address,
  output logic                           mem_write_enable,
  output logic [DATA_W-1:0]              mem_write_data,
  input  logic [DATA_W-1:0]              mem_read_data,
  output logic [ADDR_W-1:0]              pc,
  output logic [DATA_W-1:0]              tos,
  output logic [$clog2(STACK_DEPTH):0]   depth,
  output logic                           busy,
  output logic                           error
);

  localparam int CW = $clog2(STACK_DEPTH) + 1;

  state_t            state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [DATA_W-1:0] ir_q;
  logic              error_q;

  opcode_t           op;
  logic [ADDR_W-1:0] op_addr;
  logic [DATA_W-1:0] st_tos, st_nos, alu_res;
  logic [CW-1:0]     st_depth;
  logic              st_full, st_empty;
  logic              fault, in_exec, exec_ok, start_ok, mem_op;

  assign op       = opcode_t'(ir_q[DATA_W-1 -: OPC_W]);
  assign op_addr  = ir_q[ADDR_W-1:0];
  assign in_exec  = (state_q == ST_EXEC);
  assign exec_ok  = in_exec && !fault;
  assign start_ok = start && (state_q == ST_IDLE || state_q == ST_HALT);
  assign mem_op   = (op == OP_PUSH) || (op == OP_POP);

  always_comb begin
    fault = 1'b0;
    case (op)
      OP_ADD, OP_SUB, OP_AND:   fault = (st_depth < CW'(2));
      OP_NOT, OP_POP, OP_JUMPZ: fault = st_empty;
      OP_PUSH:                  fault = st_full;
      default:                  fault = 1'b0;
    endcase
  end

  always_comb begin
    alu_res = '0;
    case (op)
      OP_ADD:  alu_res = st_nos + st_tos;
      OP_SUB:  alu_res = st_nos - st_tos;
      OP_AND:  alu_res = st_nos & st_tos;
      OP_NOT:  alu_res = ~st_tos;
      default: alu_res = '0;
    endcase
  end

  // Memory strobes decode only registered state/ir, so they are stable well before negedge.
  assign mem_address      = (in_exec && mem_op) ? op_addr : pc_q;
  assign mem_write_enable = exec_ok && (op == OP_POP);
  assign mem_write_data   = (in_exec && op == OP_POP) ? st_tos : '0;

  stack_file #(.DEPTH(STACK_DEPTH)) u_stack (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear_i    (start_ok),
    .push_i     (exec_ok && op == OP_PUSH),
    .push_dat_i (mem_read_data),
    .pop_i      (exec_ok && (is_binop(op) || op == OP_POP)),
    .wr_top_i   (exec_ok && op == OP_NOT),
    .wr_nos_i   (exec_ok && is_binop(op)),
    .wr_dat_i   (alu_res),
    .tos_o      (st_tos),
    .nos_o      (st_nos),
    .depth_o    (st_depth),
    .full_o     (st_full),
    .empty_o    (st_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      error_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_HALT: begin
          if (start) begin
            state_q <= ST_FETCH;
            pc_q    <= RESET_PC;
            error_q <= 1'b0;
          end
        end
        ST_FETCH: begin
          ir_q    <= mem_read_data;
          pc_q    <= pc_q + ADDR_W'(1);
          state_q <= ST_EXEC;
        end
        ST_EXEC: begin
          if (fault) begin
            error_q <= 1'b1;
            state_q <= ST_HALT;
          end else begin
            state_q <= ST_FETCH;
            if (op == OP_JUMP || (op == OP_JUMPZ && st_tos == '0)) pc_q <= op_addr;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign pc    = pc_q;
  assign tos   = st_tos;
  assign depth = st_depth;
  assign busy  = (state_q == ST_FETCH) || (state_q == ST_EXEC);
  assign error = error_q;

endmodule
